// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF blocks.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } ro_ctrl_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Galois form, shifting right
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One Galois step: shift right, fold taps in when the outgoing bit is 1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ro_puf_lfsr16.sv
// 16-bit Galois LFSR with seed load and single-step advance.
// A zero seed would lock the register up, so it is replaced by the default seed.
module ro_puf_lfsr16
    import ro_puf_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Load has priority over step
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/ro_puf_eval_ctrl.sv
// RO-PUF evaluation controller: for each response bit, picks an RO pair from
// the LFSR, clears the counters, runs the pair for a window, lets the counts
// settle, then compares them into the response word.
module ro_puf_eval_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_RO       = 16,
    parameter int CNT_W      = 16,
    parameter int WIN_CYCLES = 1024,
    parameter int SETTLE_CYC = 4,
    parameter int RESP_BITS  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             challenge,
    output logic                    ro_en,
    output logic [$clog2(N_RO)-1:0] ro_sel_a,
    output logic [$clog2(N_RO)-1:0] ro_sel_b,
    output logic                    cnt_clr,
    input  logic [CNT_W-1:0]        cnt_a,
    input  logic [CNT_W-1:0]        cnt_b,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             response,
    output logic [5:0]              tie_cnt,
    output logic                    sat_err
);

    localparam int SEL_W    = $clog2(N_RO);
    localparam int MAX_WAIT = (WIN_CYCLES > SETTLE_CYC) ? WIN_CYCLES : SETTLE_CYC;
    localparam int TMR_W    = $clog2(MAX_WAIT + 1);

    localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [4:0]       LAST_BIT    = 5'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ALL_ONES = '1;

    ro_ctrl_state_t   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [4:0]       bit_q, bit_d;
    logic [31:0]      resp_q, resp_d;
    logic [5:0]       tie_q, tie_d;
    logic             sat_q, sat_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;

    logic             accept;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [15:0]      lfsr_state;
    logic [SEL_W-1:0] sel_a_raw;
    logic [SEL_W-1:0] sel_b_raw;
    logic             unused_bits;

    // Start is only honoured from IDLE, and abort wins over it
    assign accept    = (state_q == IDLE) && start && !abort;
    assign sel_a_raw = lfsr_state[SEL_W-1:0];
    assign sel_b_raw = lfsr_state[SEL_W+7:8];
    assign unused_bits = ^{challenge[31:16], lfsr_state[15:SEL_W+8], lfsr_state[7:SEL_W]};

    ro_puf_lfsr16 u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .seed  (challenge[15:0]),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            resp_q  <= '0;
            tie_q   <= '0;
            sat_q   <= 1'b0;
            sel_a_q <= '0;
            sel_b_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            sat_q   <= sat_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    // Next-state logic; abort from any busy state returns straight to IDLE
    always_comb begin
        state_d = state_q;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = CLEAR;
                CLEAR:   state_d = RUN;
                RUN:     if (tmr_q == '0) state_d = SETTLE;
                SETTLE:  if (tmr_q == '0) state_d = COMPARE;
                COMPARE: state_d = (bit_q == LAST_BIT) ? DONE : CLEAR;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath: window/settle timer, pair selection and result accumulation.
    // On abort nothing is updated so the partial result stays readable.
    always_comb begin
        tmr_d     = tmr_q;
        bit_d     = bit_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        sat_d     = sat_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (accept) begin
            lfsr_load = 1'b1;
            bit_d     = '0;
            resp_d    = '0;
            tie_d     = '0;
            sat_d     = 1'b0;
        end else if (!abort) begin
            unique case (state_q)
                CLEAR: begin
                    tmr_d   = WIN_LOAD;
                    sel_a_d = sel_a_raw;
                    // Comparing an RO against itself is meaningless; use its neighbour
                    sel_b_d = (sel_b_raw == sel_a_raw) ? (sel_a_raw ^ SEL_W'(1)) : sel_b_raw;
                end
                RUN: begin
                    tmr_d = (tmr_q == '0) ? SETTLE_LOAD : (tmr_q - TMR_W'(1));
                end
                SETTLE: begin
                    if (tmr_q != '0) tmr_d = tmr_q - TMR_W'(1);
                end
                COMPARE: begin
                    resp_d[bit_q] = (cnt_a > cnt_b);
                    if ((cnt_a == cnt_b) && (tie_q != 6'd63)) tie_d = tie_q + 6'd1;
                    if ((cnt_a == CNT_ALL_ONES) || (cnt_b == CNT_ALL_ONES)) sat_d = 1'b1;
                    lfsr_step = 1'b1;
                    bit_d     = bit_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        ro_en   = (state_q == RUN);
        cnt_clr = (state_q == CLEAR);
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
    end

    assign ro_sel_a = sel_a_q;
    assign ro_sel_b = sel_b_q;
    assign response = resp_q;
    assign tie_cnt  = tie_q;
    assign sat_err  = sat_q;

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// Scoreboard bench for ro_puf_eval_ctrl with a behavioural reference model.
module tb_ro_puf_eval_ctrl;

    localparam int N_RO    = 16;
    localparam int WIN     = 8;
    localparam int SET     = 2;
    localparam int RB      = 4;
    localparam int EXP_LAT = RB * (WIN + SET + 2) + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] challenge = '0;
    logic        ro_en;
    logic [3:0]  ro_sel_a;
    logic [3:0]  ro_sel_b;
    logic        cnt_clr;
    logic [15:0] cnt_a = '0;
    logic [15:0] cnt_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] response;
    logic [5:0]  tie_cnt;
    logic        sat_err;

    int asserts  = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] resp;
        logic [5:0]  tie;
        logic        sat;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  sel_q[$];
    logic [31:0] cnt_q[$];
    logic [15:0] ca[RB];
    logic [15:0] cb[RB];
    logic [31:0] m_resp, part_resp;
    logic [5:0]  m_tie, part_tie;
    logic        m_sat;
    logic        prev_en   = 1'b0;
    logic        prev_done = 1'b0;

    ro_puf_eval_ctrl #(
        .N_RO       (N_RO),
        .CNT_W      (16),
        .WIN_CYCLES (WIN),
        .SETTLE_CYC (SET),
        .RESP_BITS  (RB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .challenge (challenge),
        .ro_en     (ro_en),
        .ro_sel_a  (ro_sel_a),
        .ro_sel_b  (ro_sel_b),
        .cnt_clr   (cnt_clr),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .busy      (busy),
        .done      (done),
        .response  (response),
        .tie_cnt   (tie_cnt),
        .sat_err   (sat_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_q();
        exp_q.delete();
        sel_q.delete();
        cnt_q.delete();
    endtask

    // Reference model: walks the LFSR sequence arithmetically and derives the
    // pair per bit plus the final response/tie/saturation outcome.
    task automatic model(input logic [31:0] chal);
        int s, a, b;
        s = (chal[15:0] == 16'h0) ? 'hACE1 : int'(chal[15:0]);
        m_resp = '0; m_tie = '0; m_sat = 1'b0;
        part_resp = '0; part_tie = '0;
        for (int k = 0; k < RB; k++) begin
            a = s % 16;
            b = (s / 256) % 16;
            if (a == b) b = a ^ 1;
            sel_q.push_back({4'(a), 4'(b)});
            cnt_q.push_back({ca[k], cb[k]});
            if (ca[k] > cb[k]) m_resp = m_resp | (32'd1 << k);
            if (ca[k] == cb[k] && m_tie < 6'd63) m_tie = m_tie + 6'd1;
            if (ca[k] == 16'hFFFF || cb[k] == 16'hFFFF) m_sat = 1'b1;
            if (k == 0) begin part_resp = m_resp; part_tie = m_tie; end
            s = (s % 2 == 1) ? ((s / 2) ^ 'hB400) : (s / 2);
        end
    endtask

    task automatic rand_counts();
        for (int k = 0; k < RB; k++) begin
            case ($urandom_range(0, 3))
                0: begin ca[k] = 16'($urandom); cb[k] = ca[k]; end
                1: begin ca[k] = 16'hFFFF; cb[k] = 16'($urandom); end
                2: begin ca[k] = 16'($urandom_range(0, 300)); cb[k] = 16'hFFFF; end
                default: begin ca[k] = 16'($urandom_range(0, 300)); cb[k] = 16'($urandom_range(0, 300)); end
            endcase
        end
    endtask

    task automatic wait_en(input bit rising, input int n, output bit ok);
        int   seen;
        logic p;
        seen = 0;
        p    = ro_en;
        ok   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (rising ? (ro_en && !p) : (!ro_en && p)) seen++;
            p = ro_en;
            if (seen == n) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            asserts++; failures++;
            $display("FAIL wait_en: ro_en edge %0d not seen, required within 300 cycles", n);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < EXP_LAT + 50 && exp_q.size() != 0; i++) @(negedge clock);
        if (exp_q.size() != 0) begin
            asserts++; failures++;
            $display("FAIL done_timeout: no done within %0d cycles", EXP_LAT + 50);
            flush_q();
        end
        repeat (3) @(negedge clock);
        chk("sel_queue_drained", sel_q.size(), 0);
    endtask

    // mode 0: plain run, 1: extra start in RUN of bit 1,
    // 2: abort in SETTLE of bit 1, 3: reset in RUN of bit 2
    task automatic run_eval(input logic [31:0] chal, input int mode);
        exp_t e;
        bit   ok;
        model(chal);
        @(negedge clock);
        start = 1'b1;
        challenge = chal;
        if (mode < 2) begin
            e.resp = m_resp; e.tie = m_tie; e.sat = m_sat; e.start_cyc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0;
        challenge = $urandom;
        chk("busy_after_start", {31'b0, busy}, 1);
        case (mode)
            1: begin
                wait_en(1'b1, 2, ok);
                if (ok) begin
                    start = 1'b1; challenge = $urandom;
                    @(negedge clock);
                    start = 1'b0;
                end
            end
            2: begin
                wait_en(1'b0, 2, ok);
                if (ok) begin
                    abort = 1'b1;
                    @(negedge clock);
                    abort = 1'b0;
                    chk("abort_busy", {31'b0, busy}, 0);
                    chk("abort_ro_en", {31'b0, ro_en}, 0);
                    chk("abort_partial_resp", response, part_resp);
                    chk("abort_partial_tie", {26'b0, tie_cnt}, {26'b0, part_tie});
                    $display("abort: chal=0x%08h partial resp=0x%0h tie=%0d", chal, response, tie_cnt);
                end
                flush_q();
                repeat (EXP_LAT) @(negedge clock);
            end
            3: begin
                wait_en(1'b1, 3, ok);
                repeat (2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                chk("rst_mid_ro_en", {31'b0, ro_en}, 0);
                chk("rst_mid_cnt_clr", {31'b0, cnt_clr}, 0);
                chk("rst_mid_sel", {24'b0, ro_sel_a, ro_sel_b}, 0);
                chk("rst_mid_busy_done", {30'b0, busy, done}, 0);
                chk("rst_mid_response", response, 0);
                chk("rst_mid_tie_sat", {25'b0, tie_cnt, sat_err}, 0);
                $display("reset mid-run: chal=0x%08h outputs cleared", chal);
                reset = 1'b0;
                flush_q();
                repeat (3) @(negedge clock);
            end
            default: ;
        endcase
        if (mode < 2) wait_done();
    endtask

    // Monitor: invariants, pair checks, counter model drive and done scoreboard
    always @(negedge clock) begin : monitor
        exp_t        e;
        logic [7:0]  s;
        logic [31:0] v;
        if (!reset) begin
            chk("en_clr_exclusive", {31'b0, ro_en & cnt_clr}, 0);
            if (cnt_clr && cnt_q.size() != 0) begin
                v = cnt_q.pop_front();
                cnt_a = v[31:16];
                cnt_b = v[15:0];
            end
            if (ro_en && !prev_en) begin
                if (sel_q.size() == 0) begin
                    asserts++; failures++;
                    $display("FAIL unexpected_run: ro_en rose with no evaluation pending");
                end else begin
                    s = sel_q.pop_front();
                    chk("sel_a", {28'b0, ro_sel_a}, {28'b0, s[7:4]});
                    chk("sel_b", {28'b0, ro_sel_b}, {28'b0, s[3:0]});
                    chk("sel_distinct", {31'b0, ro_sel_a == ro_sel_b}, 0);
                end
            end
            if (prev_done) chk("busy_drop_after_done", {30'b0, busy, done}, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    asserts++; failures++;
                    $display("FAIL unexpected_done: done with no run pending (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("response", response, e.resp);
                    chk("tie_cnt", {26'b0, tie_cnt}, {26'b0, e.tie});
                    chk("sat_err", {31'b0, sat_err}, {31'b0, e.sat});
                    chk("latency", cyc - e.start_cyc, EXP_LAT);
                    chk("busy_at_done", {31'b0, busy}, 1);
                    $display("done: resp=0x%0h tie=%0d sat=%0d latency=%0d", response, tie_cnt, sat_err,
                             cyc - e.start_cyc);
                end
            end
        end
        prev_en   <= ro_en;
        prev_done <= done;
    end

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ro_en", {31'b0, ro_en}, 0);
        chk("rst_cnt_clr", {31'b0, cnt_clr}, 0);
        chk("rst_sel", {24'b0, ro_sel_a, ro_sel_b}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_response", response, 0);
        chk("rst_tie_sat", {25'b0, tie_cnt, sat_err}, 0);

        // Zero challenge falls back to the default seed; A always faster
        for (int k = 0; k < RB; k++) begin ca[k] = 16'd100; cb[k] = 16'd50; end
        run_eval(32'h0000_0000, 0);

        // All ties
        for (int k = 0; k < RB; k++) begin ca[k] = 16'd77; cb[k] = 16'd77; end
        run_eval(32'h0000_1234, 0);

        // Saturated count on bit 2 only
        for (int k = 0; k < RB; k++) begin ca[k] = 16'd5; cb[k] = 16'd10; end
        ca[2] = 16'hFFFF;
        run_eval(32'h5A5A_0001 | 32'($urandom_range(0, 16'hFFF0)), 0);

        // Start while busy must be ignored
        rand_counts();
        run_eval($urandom, 1);

        // Abort mid-run, then a full evaluation
        rand_counts();
        run_eval($urandom, 2);
        rand_counts();
        run_eval($urandom, 0);

        // Reset mid-run, then a full evaluation
        rand_counts();
        run_eval($urandom, 3);
        rand_counts();
        run_eval($urandom, 0);

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            rand_counts();
            run_eval((r % 4 == 0) ? 32'($urandom & 32'hFFFF_0000) : $urandom, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
